logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined bitwise logic unit; generalises the fixed 32-bit

---
 rtl/logic_unit_pipe.sv | 70 +++++++
 tb/tb_logic_unit_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight ops, WIDTH-bit operands,
// STAGES-deep register pipe with valid/ready back-pressure.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             zero_o
);

  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d;
  logic              adv;

  always_comb begin
    res_d = '0;
    unique case (op_i)
      3'b000: res_d = a_i & b_i;
      3'b001: res_d = a_i | b_i;
      3'b010: res_d = a_i ^ b_i;
      3'b011: res_d = ~(a_i | b_i);
      3'b100: res_d = a_i & ~b_i;
      3'b101: res_d = ~(a_i ^ b_i);
      3'b110: res_d = a_i;
      3'b111: res_d = '0;
      default: res_d = '0;
    endcase
  end

  // The whole pipe moves in lockstep; a full tail blocks everything.
  assign adv        = out_ready_i | ~vld_q[STAGES-1];
  assign in_ready_o = adv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q[0] <= 1'b0;
      res_q[0] <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid_i;
      res_q[0] <= in_valid_i ? res_d : '0;
    end
  end

  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_q[g] <= 1'b0;
        res_q[g] <= '0;
      end else if (adv) begin
        vld_q[g] <= vld_q[g-1];
        res_q[g] <= res_q[g-1];
      end
    end
  end

  assign out_valid_o = vld_q[STAGES-1];
  assign y_o         = res_q[STAGES-1];
  assign zero_o      = out_valid_o & (y_o == '0);

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe at three parameter points.
// Expected values are hand-computed constants.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv, ir, ov, ordy, z;
  logic [2:0]  op;
  logic [31:0] a, b, y;

  logic        iv8, ir8, ov8, ordy8, z8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, y8;

  logic        iv4, ir4, ov4, ordy4, z4;
  logic [2:0]  op4;
  logic [31:0] a4, b4, y4;

  int nvec = 0;
  int nerr = 0;

  logic_unit_pipe #(.WIDTH(32), .STAGES(2)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(iv), .in_ready_o(ir),
    .op_i(op), .a_i(a), .b_i(b),
    .out_valid_o(ov), .out_ready_i(ordy),
    .y_o(y), .zero_o(z)
  );

  logic_unit_pipe #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(iv8), .in_ready_o(ir8),
    .op_i(op8), .a_i(a8), .b_i(b8),
    .out_valid_o(ov8), .out_ready_i(ordy8),
    .y_o(y8), .zero_o(z8)
  );

  logic_unit_pipe #(.WIDTH(32), .STAGES(4)) u_d4 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(iv4), .in_ready_o(ir4),
    .op_i(op4), .a_i(a4), .b_i(b4),
    .out_valid_o(ov4), .out_ready_i(ordy4),
    .y_o(y4), .zero_o(z4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sweep [8] = '{32'h2, 32'h6, 32'h4, 32'hFFFFFFF9,
                             32'h4, 32'hFFFFFFFB, 32'h6, 32'h0};

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iv = 0; ordy = 1; op = 0; a = 0; b = 0;
    iv8 = 0; ordy8 = 1; op8 = 0; a8 = 0; b8 = 0;
    iv4 = 0; ordy4 = 1; op4 = 0; a4 = 0; b4 = 0;
    #12 rst = 0;
    chk("rst_ov", {31'b0, ov}, 0);
    chk("rst_y", y, 0);
    chk("rst_z", {31'b0, z}, 0);
    chk("rst_ir", {31'b0, ir}, 1);
    chk("rst_ov4", {31'b0, ov4}, 0);

    // basic AND with one-cycle visible latency
    tick();
    iv = 1; op = 3'b000; a = 32'hFFFFFFFF; b = 32'h80000001;
    tick();
    iv = 0;
    chk("t1_ov_early", {31'b0, ov}, 0);
    tick();
    chk("t1_ov", {31'b0, ov}, 1);
    chk("t1_y", y, 32'h80000001);
    chk("t1_z", {31'b0, z}, 0);
    tick();

    // op sweep, back-to-back
    a = 32'h6; b = 32'h2;
    for (int k = 0; k < 8; k++) begin
      iv = 1; op = 3'(k);
      tick();
      if (k > 0) begin
        chk($sformatf("sw_ov%0d", k-1), {31'b0, ov}, 1);
        chk($sformatf("sw_y%0d", k-1), y, sweep[k-1]);
        chk($sformatf("sw_z%0d", k-1), {31'b0, z}, 0);
      end
    end
    iv = 0;
    tick();
    chk("sw_ov7", {31'b0, ov}, 1);
    chk("sw_y7", y, 32'h0);
    chk("sw_z7", {31'b0, z}, 1);
    tick();
    chk("sw_drain", {31'b0, ov}, 0);

    // stall with back-pressure
    ordy = 0;
    iv = 1; op = 3'b000;
    tick();
    op = 3'b001;
    tick();
    op = 3'b010;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("st_ir%0d", k), {31'b0, ir}, 0);
      chk($sformatf("st_ov%0d", k), {31'b0, ov}, 1);
      chk($sformatf("st_y%0d", k), y, 32'h2);
      a = 32'h0; b = 32'hFFFFFFFF;
      tick();
      a = 32'h6; b = 32'h2;
    end
    chk("st_y_hold", y, 32'h2);
    ordy = 1;
    #1;
    chk("st_ir_rel", {31'b0, ir}, 1);
    tick();
    iv = 0;
    chk("st_y1", y, 32'h6);
    tick();
    chk("st_y2", y, 32'h4);
    chk("st_ov2", {31'b0, ov}, 1);
    tick();
    chk("st_done", {31'b0, ov}, 0);

    // async reset with a full stalled pipe
    ordy = 0;
    iv = 1; op = 3'b000; a = 32'hFFFFFFFF; b = 32'h80000001;
    tick();
    op = 3'b110;
    tick();
    iv = 0;
    chk("rs_full", {31'b0, ov}, 1);
    #2 rst = 1;
    #1;
    chk("rs_ov", {31'b0, ov}, 0);
    chk("rs_y", y, 0);
    chk("rs_z", {31'b0, z}, 0);
    chk("rs_ir", {31'b0, ir}, 1);
    #2 rst = 0;
    ordy = 1;
    tick();
    iv = 1; op = 3'b001; a = 32'h6; b = 32'h2;
    tick();
    iv = 0;
    chk("rs_post_early", {31'b0, ov}, 0);
    tick();
    chk("rs_post_ov", {31'b0, ov}, 1);
    chk("rs_post_y", y, 32'h6);
    tick();

    // parameter points
    iv8 = 1; op8 = 3'b010; a8 = 8'hF0; b8 = 8'hFF;
    iv4 = 1; op4 = 3'b010; a4 = 32'hF0; b4 = 32'hFF;
    tick();
    iv8 = 0; iv4 = 0;
    chk("w8_ov", {31'b0, ov8}, 1);
    chk("w8_y", {24'b0, y8}, 32'h0F);
    chk("d4_ov0", {31'b0, ov4}, 0);
    tick();
    chk("w8_gone", {31'b0, ov8}, 0);
    chk("d4_ov1", {31'b0, ov4}, 0);
    tick();
    chk("d4_ov2", {31'b0, ov4}, 0);
    tick();
    chk("d4_ov3", {31'b0, ov4}, 1);
    chk("d4_y", y4, 32'h0F);
    tick();
    chk("d4_gone", {31'b0, ov4}, 0);

    // bubbles: zero-result ops with a hole between them
    op = 3'b111;
    iv = 1; tick();
    iv = 0; tick();
    chk("bb_ov0", {31'b0, ov}, 1);
    chk("bb_z0", {31'b0, z}, 1);
    iv = 1; tick();
    chk("bb_ov1", {31'b0, ov}, 0);
    chk("bb_z1", {31'b0, z}, 0);
    iv = 0; tick();
    chk("bb_ov2", {31'b0, ov}, 1);
    chk("bb_z2", {31'b0, z}, 1);
    tick();
    chk("bb_ov3", {31'b0, ov}, 0);
    chk("bb_z3", {31'b0, z}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
